// File: rtl/rv_pkg.sv
// Shared register-file constants and the writeback request record.
package rv_pkg;

   localparam int XLEN     = 64;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   // One-hot decode of a register index into a NUM_REGS-wide mask.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
      return NUM_REGS'(1) << r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr and wraps, first
// requester found wins. Purely combinational so the caller owns the pointer.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);

   int idx;

   // Walk ptr, ptr+1, ... mod N and latch the first active request.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register_file write port between N_REQ writeback
// sources, with a single registered output stage and a pending-write mask.
module regfile_wb_arbiter #(
   parameter  int N_REQ = 2,
   parameter  int XLEN  = 64,
   parameter  int AW    = 5,
   localparam int SW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*AW-1:0]   req_rd,
   input  logic [N_REQ*XLEN-1:0] req_data,
   output logic [N_REQ-1:0]      req_ready,
   input  logic                  hold,
   output logic                  wr_en,
   output logic [AW-1:0]         wr_reg,
   output logic [XLEN-1:0]       wr_data,
   output logic [SW-1:0]         wr_src,
   output logic [31:0]           pend_mask
);

   import rv_pkg::NUM_REGS;
   import rv_pkg::REG_ZERO;

   logic [SW-1:0]    rr_ptr;
   logic             out_vld;
   logic [N_REQ-1:0] gnt;
   logic [SW-1:0]    gnt_idx;
   logic             gnt_any;
   logic             xfer;
   logic [SW-1:0]    ptr_nxt;
   logic [AW-1:0]    sel_rd;
   logic [XLEN-1:0]  sel_data;
   logic [NUM_REGS-1:0] onehot;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Grants are suppressed while frozen or in reset; the output stage can
   // drain and refill in the same cycle, so no back-pressure from out_vld.
   assign req_ready = gnt & {N_REQ{~hold & ~rst}};
   assign xfer      = gnt_any & ~hold & ~rst;
   assign ptr_nxt   = (gnt_idx == SW'(N_REQ - 1)) ? '0 : gnt_idx + SW'(1);

   // Pick the winner's rd/data; req_ready is one-hot so an OR-mux is enough.
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            sel_rd   = req_rd[i*AW +: AW];
            sel_data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   // Output stage and round-robin pointer; hold freezes both.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         out_vld <= 1'b0;
         wr_reg  <= '0;
         wr_data <= '0;
         wr_src  <= '0;
      end else if (xfer) begin
         rr_ptr  <= ptr_nxt;
         out_vld <= 1'b1;
         wr_reg  <= sel_rd;
         wr_data <= sel_data;
         wr_src  <= gnt_idx;
      end else if (!hold) begin
         out_vld <= 1'b0;
      end
   end

   // x0 writes are consumed silently; reset discards a pending write at once.
   assign wr_en     = out_vld & (wr_reg != AW'(REG_ZERO)) & ~hold & ~rst;
   assign onehot    = NUM_REGS'(1) << wr_reg;
   assign pend_mask = wr_en ? 32'(onehot) : 32'd0;

endmodule
